fifo_reader: RTL and testbench
==============================

Name: fifo_reader

Overview:
- Drain-side controller for the 6-bit FIFO. Issues `pop` to the FIFO and captures `Fifo_Data_out` one cycle later.
- Presents words downstream with a valid/Pausa handshake. A 2-entry skid buffer absorbs the in-flight read while downstream is paused.
- Tracks FIFO occupancy with a shadow counter driven by the writer's push, so it never pops an empty FIFO. The FIFO's own registered flags lag occupancy and are not used for this.

Parameters:
- N, 4, FIFO address width; FIFO_DEPTH = 2**N.
- DATA_WIDTH, 6, data word width.
- CNT_WIDTH, 8, width of the transferred-word counter.

Ports:
- clk  in  1  clock.
- reset_L  in  1  synchronous active-low reset.
- enable  in  1  run request; 0 stops new pops.
- up_push  in  1  the push strobe seen by the FIFO (writer side).
- pop  out  1  read strobe to FIFO (combinational).
- Fifo_Data_out  in  DATA_WIDTH  FIFO read data, valid the cycle after pop.
- Fifo_Empty  in  1  FIFO empty flag (consistency check only).
- data_out  out  DATA_WIDTH  head word to downstream.
- valid_out  out  1  data_out holds a word.
- Pausa_in  in  1  downstream stall; a transfer occurs when valid_out=1 and Pausa_in=0.
- busy  out  1  state != IDLE.
- word_count  out  CNT_WIDTH  words transferred downstream, wraps.
- Error_Reader  out  1  sticky error.

Behaviour:
- Reset (clk edge with reset_L=0): state=IDLE; shadow_cnt=0; inflight=0; occ=0; valid_out=0; data_out=0; word_count=0; Error_Reader=0.
- Reset mid-operation: the in-flight read and buffered words are discarded.
- shadow_cnt (N+1 bits): +1 on up_push, −1 on pop, unchanged when both occur. It never decrements below 0.
- Shadow overflow: up_push with shadow_cnt==FIFO_DEPTH and no pop sets Error_Reader; the count saturates.
- Empty consistency: Error_Reader is also set when Fifo_Empty=1 and shadow_cnt>1. This allows for the FIFO flag's one-cycle lag.
- Error_Reader clears only on reset.
- xfer = valid_out & ~Pausa_in.
- occ_next = occ + inflight − xfer.
- pop = (state==RUN) & (shadow_cnt!=0) & (occ_next < 2). This gives 1 word/cycle sustained when Pausa_in=0.
- inflight <= pop. When inflight=1, Fifo_Data_out is written to the skid buffer tail at that edge.
- Skid buffer: 2 entries, FIFO-ordered.
  - data_out = head entry; valid_out = (occ!=0).
  - data_out and valid_out are stable while Pausa_in=1.
  - On xfer the head advances and word_count increments.
  - Capture and xfer in the same cycle are legal: occ is unchanged and the new word goes behind the current head.
- State machine:
  - IDLE → RUN when enable=1.
  - RUN → DRAIN when enable=0.
  - DRAIN: no pops. → IDLE when inflight=0 and occ=0. → RUN when enable returns to 1.
- Words pushed while the block is in IDLE still count into shadow_cnt.

Decomposition:
- Shared package (fifo_pkg):
  - DATA_WIDTH and N defaults, matching the FIFO block.
  - State encodings IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
- One natural sub-module, `skid_buffer_2`: 2-entry register FIFO with push/pop/occ.
- Controller, shadow counter and error logic stay in fifo_reader.

Test Plan:
- Stream:
  - Stimulus: reset; enable=1; 5 up_push writes of 6'h01..6'h05, one per cycle; Pausa_in=0.
  - Required: pop first asserts the cycle after the first push; data_out shows 01..05 on consecutive cycles; word_count=5; shadow_cnt=0; no pop afterwards.
- Backpressure:
  - Stimulus: 4 words queued, Pausa_in=1 for 6 cycles, then 0.
  - Required: occ peaks at 2; pop stops; data_out holds 6'h01 throughout; after release, 01..04 in order with no loss or duplication.
- Drain:
  - Stimulus: enable dropped while inflight=1 and occ=1.
  - Required: state=DRAIN; no further pop; both words delivered; state=IDLE; busy=0.
- Overflow:
  - Stimulus: 17 up_push with enable=0, N=4.
  - Required: Error_Reader=1 after the 17th push and remains 1 until reset_L=0.
- Reset mid-stream:
  - Stimulus: reset_L=0 for 1 cycle while valid_out=1 and inflight=1.
  - Required: next cycle valid_out=0, word_count=0, shadow_cnt=0, pop=0.
- Simultaneous:
  - Stimulus: up_push and pop in the same cycle with shadow_cnt=1.
  - Required: shadow_cnt stays 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and controller state encoding for the FIFO drain-side reader.
package fifo_pkg;
  localparam int N          = 4;
  localparam int DATA_WIDTH = 6;
  localparam int CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/fifo_reader_if.sv
// FIFO-side and downstream-side handshake signals of the reader.
interface fifo_reader_if #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
);
  logic                  up_push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] Fifo_Data_out;
  logic                  Fifo_Empty;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  Pausa_in;

  modport master (
    input  up_push, Fifo_Data_out, Fifo_Empty, Pausa_in,
    output pop, data_out, valid_out
  );

  modport slave (
    output up_push, Fifo_Data_out, Fifo_Empty, Pausa_in,
    input  pop, data_out, valid_out
  );
endinterface

// File: rtl/skid_buffer_2.sv
// Two-entry register FIFO; head is always the oldest word, push and pop may coincide.
module skid_buffer_2 #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset_L,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);
  logic [W-1:0] tail;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0)      head <= push_data;
          else if (occ == 2'd1) tail <= push_data;
          if (occ != 2'd2) occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          if (occ != 2'd0) occ <= occ - 2'd1;
        end
        2'b11: begin
          // New word lands behind whatever becomes the head after this pop.
          if (occ == 2'd1) head <= push_data;
          else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fifo_reader.sv
// Drain-side FIFO controller: pops against a shadow occupancy count, skid-buffers reads downstream.
module fifo_reader #(
  parameter int N          = fifo_pkg::N,
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = fifo_pkg::CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enable,
  fifo_reader_if.master        bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 Error_Reader
);
  import fifo_pkg::*;

  localparam int         FIFO_DEPTH = 2**N;
  localparam logic [N:0] FULL_CNT   = (N+1)'(FIFO_DEPTH);

  state_t     state, state_nxt;
  logic [N:0] shadow_cnt;
  logic       inflight;
  logic       xfer;
  logic [1:0] occ;
  logic [2:0] occ_next;

  assign xfer          = bus.valid_out & ~bus.Pausa_in;
  assign occ_next      = {1'b0, occ} + {2'b00, inflight} - {2'b00, xfer};
  assign bus.valid_out = (occ != 2'd0);

  skid_buffer_2 #(.W(DATA_WIDTH)) u_skid (
    .clk      (clk),
    .reset_L  (reset_L),
    .push     (inflight),
    .pop      (xfer),
    .push_data(bus.Fifo_Data_out),
    .head     (bus.data_out),
    .occ      (occ)
  );

  always_ff @(posedge clk) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)                            state_nxt = RUN;
        else if (!inflight && occ == 2'd0)     state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // occ_next < 2 guarantees the word still in flight always finds a free slot.
  always_comb begin
    busy    = (state != IDLE);
    bus.pop = (state == RUN) && (shadow_cnt != '0) && (occ_next < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      shadow_cnt   <= '0;
      inflight     <= 1'b0;
      word_count   <= '0;
      Error_Reader <= 1'b0;
    end else begin
      inflight <= bus.pop;
      if (xfer) word_count <= word_count + 1'b1;
      if (bus.up_push && !bus.pop) begin
        if (shadow_cnt == FULL_CNT) Error_Reader <= 1'b1;
        else                        shadow_cnt   <= shadow_cnt + 1'b1;
      end else if (bus.pop && !bus.up_push && shadow_cnt != '0) begin
        shadow_cnt <= shadow_cnt - 1'b1;
      end
      // The FIFO flag lags by a cycle, so a count of 1 against Empty is tolerated.
      if (bus.Fifo_Empty && shadow_cnt > (N+1)'(1)) Error_Reader <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: FIFO model plus scoreboard of pushed words, table runs and corner sequences.
module tb_fifo_reader;
  import fifo_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset_L, enable;
  logic                 busy, Error_Reader;
  logic [CNT_WIDTH-1:0] word_count;

  fifo_reader_if bus ();

  fifo_reader dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .enable      (enable),
    .bus         (bus),
    .busy        (busy),
    .word_count  (word_count),
    .Error_Reader(Error_Reader)
  );

  always #5 clk = ~clk;

  typedef struct { int nwords; int pause; int exp_count; } vec_t;
  vec_t vecs[5];

  int errors = 0;
  int checks = 0;
  logic [DATA_WIDTH-1:0] fifo_q[$];
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic                  empty_force = 1'b0;
  logic [DATA_WIDTH-1:0] wdata = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: sample handshakes mid-cycle, then update the FIFO model just after the edge.
  task automatic tick();
    logic pop_s, push_s;
    logic [DATA_WIDTH-1:0] d, e;
    @(negedge clk);
    pop_s  = bus.pop;
    push_s = bus.up_push;
    d      = wdata;
    if (pop_s) chk("pop_nonempty", 32'(fifo_q.size() != 0), 32'd1);
    if (reset_L && bus.valid_out && !bus.Pausa_in) begin
      if (exp_q.size() == 0) chk("sb_extra_word", 32'(bus.data_out), 32'hffff_ffff);
      else begin
        e = exp_q.pop_front();
        chk("sb_data", 32'(bus.data_out), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    if (pop_s && fifo_q.size() != 0) bus.Fifo_Data_out = fifo_q.pop_front();
    if (push_s) fifo_q.push_back(d);
    bus.Fifo_Empty = (fifo_q.size() == 0) || empty_force;
  endtask

  task automatic push_word(input logic [DATA_WIDTH-1:0] d, input bit track);
    bus.up_push = 1'b1;
    wdata       = d;
    if (track) exp_q.push_back(d);
    tick();
    bus.up_push = 1'b0;
  endtask

  task automatic do_reset();
    reset_L     = 1'b0;
    enable      = 1'b0;
    bus.up_push = 1'b0;
    bus.Pausa_in = 1'b0;
    empty_force = 1'b0;
    tick();
    reset_L = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    bus.Fifo_Empty = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(bus.valid_out == 1'b0 && dut.inflight == 1'b0 && dut.shadow_cnt == '0) && n < 200) begin
      tick();
      n++;
    end
    chk(name, 32'(n < 200), 32'd1);
  endtask

  initial begin
    vecs[0] = '{1, 0, 1};
    vecs[1] = '{3, 2, 3};
    vecs[2] = '{6, 0, 6};
    vecs[3] = '{2, 5, 2};
    vecs[4] = '{16, 3, 16};

    reset_L = 1'b0; enable = 1'b0;
    bus.up_push = 1'b0; bus.Pausa_in = 1'b0;
    bus.Fifo_Data_out = '0; bus.Fifo_Empty = 1'b1;

    // Reset state
    do_reset();
    chk("rst_state",   32'(dut.state), 32'(IDLE));
    chk("rst_shadow",  32'(dut.shadow_cnt), 32'd0);
    chk("rst_valid",   32'(bus.valid_out), 32'd0);
    chk("rst_data",    32'(bus.data_out), 32'd0);
    chk("rst_count",   32'(word_count), 32'd0);
    chk("rst_err",     32'(Error_Reader), 32'd0);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_pop",     32'(bus.pop), 32'd0);

    // Stream, including push+pop in the same cycle at shadow_cnt==1
    do_reset(); enable = 1'b1; tick();
    for (int i = 1; i <= 5; i++) begin
      bus.up_push = 1'b1; wdata = DATA_WIDTH'(i); exp_q.push_back(wdata);
      #1;
      chk("stream_pop", 32'(bus.pop), 32'(i > 1));
      tick();
      chk("stream_shadow_hold", 32'(dut.shadow_cnt), 32'd1);
    end
    bus.up_push = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      chk("stream_valid", 32'(bus.valid_out), 32'd1);
      chk("stream_data", 32'(bus.data_out), 32'(k));
      tick();
    end
    chk("stream_done_valid", 32'(bus.valid_out), 32'd0);
    chk("stream_count", 32'(word_count), 32'd5);
    chk("stream_shadow", 32'(dut.shadow_cnt), 32'd0);
    chk("stream_pop_after", 32'(bus.pop), 32'd0);
    tick();
    chk("stream_pop_after2", 32'(bus.pop), 32'd0);

    // Backpressure
    do_reset(); enable = 1'b1; bus.Pausa_in = 1'b1; tick();
    for (int i = 1; i <= 4; i++) push_word(DATA_WIDTH'(i), 1'b1);
    for (int c = 0; c < 6; c++) begin
      chk("bp_occ", 32'(dut.occ), 32'd2);
      chk("bp_pop", 32'(bus.pop), 32'd0);
      chk("bp_hold", 32'(bus.data_out), 32'd1);
      tick();
    end
    bus.Pausa_in = 1'b0;
    wait_drain("bp_drain");
    chk("bp_count", 32'(word_count), 32'd4);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Drain: words queued while idle, enable dropped with one in flight and one buffered
    do_reset();
    for (int i = 1; i <= 4; i++) push_word(DATA_WIDTH'(i), 1'b1);
    chk("idle_shadow", 32'(dut.shadow_cnt), 32'd4);
    chk("idle_pop", 32'(bus.pop), 32'd0);
    enable = 1'b1;
    tick(); tick(); tick();
    chk("dr_inflight", 32'(dut.inflight), 32'd1);
    chk("dr_occ", 32'(dut.occ), 32'd1);
    enable = 1'b0;
    tick();
    chk("dr_state", 32'(dut.state), 32'(DRAIN));
    for (int n = 0; n < 20 && dut.state != IDLE; n++) begin
      chk("dr_no_pop", 32'(bus.pop), 32'd0);
      tick();
    end
    chk("dr_idle", 32'(dut.state), 32'(IDLE));
    chk("dr_busy", 32'(busy), 32'd0);
    chk("dr_count", 32'(word_count), 32'd3);
    chk("dr_shadow_left", 32'(dut.shadow_cnt), 32'd1);
    chk("dr_sb_left", 32'(exp_q.size()), 32'd1);

    // Shadow overflow
    do_reset();
    for (int i = 1; i <= 16; i++) push_word(DATA_WIDTH'(i), 1'b0);
    chk("ovf_err_16", 32'(Error_Reader), 32'd0);
    chk("ovf_shadow_16", 32'(dut.shadow_cnt), 32'd16);
    push_word(DATA_WIDTH'(17), 1'b0);
    chk("ovf_err_17", 32'(Error_Reader), 32'd1);
    chk("ovf_sat", 32'(dut.shadow_cnt), 32'd16);
    repeat (3) tick();
    chk("ovf_sticky", 32'(Error_Reader), 32'd1);
    do_reset();
    chk("ovf_cleared", 32'(Error_Reader), 32'd0);

    // Empty-flag consistency: one word of lag tolerated, two is an error
    do_reset();
    push_word(DATA_WIDTH'(1), 1'b0);
    empty_force = 1'b1;
    tick(); tick();
    chk("empty_lag_ok", 32'(Error_Reader), 32'd0);
    push_word(DATA_WIDTH'(2), 1'b0);
    tick();
    chk("empty_mismatch", 32'(Error_Reader), 32'd1);

    // Reset mid-stream
    do_reset(); enable = 1'b1; tick();
    for (int i = 1; i <= 3; i++) push_word(DATA_WIDTH'(i), 1'b1);
    chk("mid_pre_valid", 32'(bus.valid_out), 32'd1);
    chk("mid_pre_inflight", 32'(dut.inflight), 32'd1);
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    fifo_q.delete(); exp_q.delete(); bus.Fifo_Empty = 1'b1;
    chk("mid_valid", 32'(bus.valid_out), 32'd0);
    chk("mid_count", 32'(word_count), 32'd0);
    chk("mid_shadow", 32'(dut.shadow_cnt), 32'd0);
    chk("mid_pop", 32'(bus.pop), 32'd0);
    tick();
    chk("mid_run_pop", 32'(bus.pop), 32'd0);

    // Table-driven runs
    for (int v = 0; v < 5; v++) begin
      do_reset(); enable = 1'b1; bus.Pausa_in = (vecs[v].pause > 0); tick();
      for (int i = 0; i < vecs[v].nwords; i++) push_word(DATA_WIDTH'(v*8 + i + 1), 1'b1);
      repeat (vecs[v].pause) tick();
      bus.Pausa_in = 1'b0;
      wait_drain("tbl_drain");
      chk("tbl_count", 32'(word_count), 32'(vecs[v].exp_count));
      chk("tbl_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("tbl_err", 32'(Error_Reader), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
